// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte sources.
// Optional baud-tick watchdog on a stalled serializer: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned GAP_BITS = 1,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_baud_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [8*NREQ-1:0]       data_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    ena_tx_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_busy_i,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    err_o
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            ena_q, ena_d;
  logic [7:0]      data_q, data_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            busy_q, busy_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [OW-1:0] cand;

  // Round-robin search starting just after the last owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = owner_q;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = OW'((32'(owner_q) + i) % NREQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = '0;
    ena_d   = ena_q;
    data_d  = data_q;
    gap_d   = gap_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          data_d  = data_i[{win_idx, 3'b000} +: 8];
          gnt_d   = NREQ'(1) << win_idx;
          ena_d   = 1'b1;
          state_d = S_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_START: begin
        if (tx_busy_i) begin
          ena_d   = 1'b0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy_i) begin
          gap_d   = '0;
          state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (clk_baud_i && (gap_q != GW'(GAP_BITS))) gap_d = gap_q + 1'b1;
        if (gap_d == GW'(GAP_BITS)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog overrides the normal handshake; the aborted byte is dropped
    if ((state_q == S_START || state_q == S_WAIT_DONE) && clk_baud_i) begin
      wd_d = wd_q + 1'b1;
      if (wd_d == WW'(TIMEOUT)) begin
        ena_d   = 1'b0;
        err_d   = 1'b1;
        gap_d   = '0;
        state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
      end
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= OW'(NREQ - 1);
      gnt_q   <= '0;
      ena_q   <= 1'b0;
      data_q  <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ena_q   <= ena_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign ena_tx_o  = ena_q;
  assign tx_data_o = data_q;
  assign busy_o    = busy_q;
  assign owner_o   = owner_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued by the
// stimulus and popped by a monitor whenever gnt_o pulses.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned GAP_BITS = 1;
  localparam int unsigned TIMEOUT  = 16;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_baud;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt_o;
  logic        ena_tx_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy;
  logic        busy_o;
  logic [1:0]  owner_o;
  logic        err_o;

  logic ser_busy = 1'b0;
  logic man_busy = 1'b0;
  bit   ser_auto = 1'b0;
  assign tx_busy = ser_busy | man_busy;

  uart_tx_arbiter #(.NREQ(NREQ), .GAP_BITS(GAP_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .clk_baud_i(clk_baud), .req_i(req), .data_i(data),
    .gnt_o(gnt_o), .ena_tx_o(ena_tx_o), .tx_data_o(tx_data_o), .tx_busy_i(tx_busy),
    .busy_o(busy_o), .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
    logic [1:0] owner;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   err_seen = 0;
  int   tick_cnt = 0;
  bit   had_frame = 1'b0;
  int   ser_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
    exp_t x;
    x.gnt = g; x.data = d; x.owner = o;
    exp_q.push_back(x);
  endtask

  // Baud strobe: one cycle high every 4 clocks
  initial begin
    clk_baud = 1'b0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        clk_baud = (i == 3);
      end
    end
  end

  // Serializer model: busy for 10 baud ticks per frame
  initial begin
    forever begin
      @(posedge clk); #2;
      if (ser_auto && ena_tx_o && !tx_busy) begin
        ser_busy = 1'b1;
        ser_n = 0;
        while (ser_n < 10) begin
          @(posedge clk); #2;
          if (clk_baud) ser_n++;
        end
        ser_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every grant and checks the idle gap
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        had_frame = 1'b0;
        tick_cnt  = 0;
      end else begin
        if (err_o) err_seen++;
        if (|gnt_o) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_grant: got gnt=%b expected none", gnt_o);
          end else begin
            e = exp_q.pop_front();
            check("grant", 32'({gnt_o, tx_data_o, owner_o, ena_tx_o, busy_o}),
                  32'({e.gnt, e.data, e.owner, 2'b11}));
          end
          if (had_frame) begin
            n_cmp++;
            if (tick_cnt < int'(GAP_BITS) || tick_cnt > int'(GAP_BITS) + 1) begin
              n_err++;
              $display("FAIL gap_ticks: got %0d expected %0d..%0d", tick_cnt, GAP_BITS, GAP_BITS + 1);
            end
          end
          had_frame = 1'b1;
          tick_cnt  = 0;
        end else if (clk_baud && busy_o && !ena_tx_o && !tx_busy) begin
          tick_cnt++;
        end
      end
    end
  end

  task automatic wait_grant(input logic [3:0] mask, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if ((gnt_o & mask) != 4'b0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL grant_timeout: got no grant expected mask %b", mask);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      if (!busy_o && !tx_busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy_o=%b expected 0", busy_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  cnt;
    int  n;
    bit  got;
    bit  any;
    rst  = 1'b1;
    req  = 4'b1111;
    data = {8'h46, 8'h35, 8'h24, 8'h13};
    repeat (3) @(posedge clk);
    #2;
    check("rst_gnt",   32'(gnt_o), 0);
    check("rst_ena",   32'(ena_tx_o), 0);
    check("rst_data",  32'(tx_data_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    check("rst_err",   32'(err_o), 0);
    check("rst_owner", 32'(owner_o), 3);

    // Round-robin with all requesters active
    ser_auto = 1'b1;
    push(4'b0001, 8'h13, 2'd0);
    push(4'b0010, 8'h24, 2'd1);
    push(4'b0100, 8'h35, 2'd2);
    push(4'b1000, 8'h46, 2'd3);
    push(4'b0001, 8'h13, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(1000);
    req = 4'b0000;
    wait_idle(200);

    // Single requester, back-to-back bytes
    data[23:16] = 8'h55;
    req = 4'b0100;
    push(4'b0100, 8'h55, 2'd2);
    push(4'b0100, 8'hA3, 2'd2);
    wait_grant(4'b0100, 200);
    @(posedge clk); #2;
    data[23:16] = 8'hA3;
    wait_grant(4'b0100, 200);
    req = 4'b0000;
    wait_idle(200);
    check("data_hold", 32'(tx_data_o), 32'h0000_00A3);

    // Delayed busy handshake
    ser_auto = 1'b0;
    req = 4'b1000;
    push(4'b1000, 8'h46, 2'd3);
    wait_grant(4'b1000, 200);
    cnt = ena_tx_o ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #2;
      if (ena_tx_o) cnt++;
      if (i == 5) man_busy = 1'b1;
    end
    check("ena_len", 32'(cnt), 6);
    any = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      if (|gnt_o) any = 1'b1;
    end
    check("no_grant_while_busy", 32'(any), 0);
    check("busy_in_wait", 32'(busy_o), 1);
    push(4'b1000, 8'h46, 2'd3);
    ser_auto = 1'b1;
    man_busy = 1'b0;
    wait_grant(4'b1000, 200);
    req = 4'b0000;
    wait_idle(200);

    // Reset during WAIT_DONE
    req = 4'b0010;
    push(4'b0010, 8'h24, 2'd1);
    wait_grant(4'b0010, 200);
    req = 4'b0000;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #2;
      if (tx_busy && !ena_tx_o && busy_o) got = 1'b1;
    end
    check("reached_wait_done", 32'(got), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_busy",  32'(busy_o), 0);
    check("async_ena",   32'(ena_tx_o), 0);
    check("async_gnt",   32'(gnt_o), 0);
    check("async_owner", 32'(owner_o), 3);
    for (int i = 0; i < 100 && tx_busy; i++) @(posedge clk);
    req = 4'b1111;
    push(4'b0001, 8'h13, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_grant(4'b0001, 50);
    req = 4'b0000;
    wait_idle(200);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Stalled serializer: watchdog abort, then next requester
    ser_auto = 1'b0;
    req = 4'b0011;
    push(4'b0010, 8'h24, 2'd1);
    wait_grant(4'b0010, 50);
    req = 4'b0001;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (clk_baud) n++;
      @(posedge clk); #2;
      if (err_o) got = 1'b1;
    end
    check("timeout_ticks", 32'(n), 32'(TIMEOUT));
    check("timeout_ena",   32'(ena_tx_o), 0);
    push(4'b0001, 8'h13, 2'd0);
    ser_auto = 1'b1;
    wait_grant(4'b0001, 100);
    req = 4'b0000;
    wait_idle(200);
`else
    n = 0;
`endif

    @(posedge clk); #2;
    check("err_pulses", 32'(err_seen), 32'(EXP_ERR));
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
